// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Round-robin Wishbone bus arbiter with a bus watchdog. Grants the shared bus
// to one master per cyc tenure (no preemption) and aborts transfers whose
// slave never answers by pulsing tmo_err_o for one cycle while keeping the
// grant. All outputs are registered; there are no input-to-output
// combinational paths.
//
// Parameters:
//   MASTERS_NUM  number of requesting masters (1..8)
//   IDX_WIDTH    width of gnt_idx_o, >= max(1, clog2(MASTERS_NUM))
//   TIMEOUT      watchdog wait-state limit (0..65535), 0 disables it
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-low reset
//   m_cyc_i      per-master cyc, bit i = master i
//   m_stb_i      per-master stb
//   s_ack_i      ack from the selected slave (after the intercon mux)
//   s_err_i      err from the selected slave (after the intercon mux)
//   gnt_o        one-hot grant, zero when idle
//   gnt_idx_o    binary index of the granted master, holds when idle
//   gnt_valid_o  high while a grant is active
//   tmo_err_o    one-cycle watchdog abort pulse to the granted master
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int unsigned MASTERS_NUM = 2,
  parameter int unsigned IDX_WIDTH   = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [MASTERS_NUM-1:0] m_cyc_i,
  input  logic [MASTERS_NUM-1:0] m_stb_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [MASTERS_NUM-1:0] gnt_o,
  output logic [IDX_WIDTH-1:0]   gnt_idx_o,
  output logic                   gnt_valid_o,
  output logic                   tmo_err_o
);

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
  localparam bit          WdEnable   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StAbort
  } state_e;

  state_e                 r_state;
  logic [15:0]            r_wd_cnt;
  logic [MASTERS_NUM-1:0] r_gnt;
  // Index of the current/most recent grant; doubles as the round-robin
  // pointer (last_idx), since both always hold the same value.
  logic [IDX_WIDTH-1:0]   r_gnt_idx;
  logic                   r_gnt_valid;
  logic                   r_tmo_err;

  logic                   w_pick_found;
  logic [IDX_WIDTH-1:0]   w_pick_idx;
  logic [MASTERS_NUM-1:0] w_pick_oh;
  logic                   w_cur_cyc;
  logic                   w_cur_stb;
  logic                   w_done;

  // Round-robin pick: scan upward from last_idx+1 with wrap-around, so the
  // master just served has the lowest priority for the next tenure.
  always_comb begin
    int unsigned            cand;
    logic [MASTERS_NUM-1:0] cand_oh;
    w_pick_found = 1'b0;
    w_pick_idx   = r_gnt_idx;
    w_pick_oh    = '0;
    cand         = 0;
    cand_oh      = '0;
    for (int unsigned off = 1; off <= MASTERS_NUM; off++) begin
      cand    = (32'(r_gnt_idx) + off) % MASTERS_NUM;
      cand_oh = MASTERS_NUM'(1) << cand;
      if (!w_pick_found && (|(m_cyc_i & cand_oh))) begin
        w_pick_found = 1'b1;
        w_pick_idx   = IDX_WIDTH'(cand);
        w_pick_oh    = cand_oh;
      end
    end
  end

  // The grant vector is one-hot while a tenure is active, so masking with it
  // selects the owner's cyc/stb without a variable bit index.
  assign w_cur_cyc = |(m_cyc_i & r_gnt);
  assign w_cur_stb = |(m_stb_i & r_gnt);
  // ack and err together still count as a single completion.
  assign w_done    = s_ack_i | s_err_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= StIdle;
      r_wd_cnt    <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= IDX_WIDTH'(MASTERS_NUM - 1);
      r_gnt_valid <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_tmo_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_wd_cnt <= '0;
          if (w_pick_found) begin
            r_gnt       <= w_pick_oh;
            r_gnt_idx   <= w_pick_idx;
            r_gnt_valid <= 1'b1;
            r_state     <= StGrant;
          end
        end

        StGrant: begin
          if (!w_cur_cyc) begin
            // Release has priority over a timeout on the same edge.
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_wd_cnt    <= '0;
            r_state     <= StIdle;
          end else if (WdEnable && w_cur_stb && !w_done) begin
            if (r_wd_cnt == TimeoutVal) begin
              r_tmo_err <= 1'b1;
              r_wd_cnt  <= '0;
              r_state   <= StAbort;
            end else begin
              r_wd_cnt <= r_wd_cnt + 16'd1;
            end
          end else begin
            // Completion (even on the limit cycle) or idle stb restarts it.
            r_wd_cnt <= '0;
          end
        end

        StAbort: begin
          r_wd_cnt <= '0;
          if (!w_cur_cyc) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_state     <= StIdle;
          end else begin
            r_state <= StGrant;
          end
        end

        default: begin
          r_state     <= StIdle;
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
          r_wd_cnt    <= '0;
        end
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_idx_o   = r_gnt_idx;
  assign gnt_valid_o = r_gnt_valid;
  assign tmo_err_o   = r_tmo_err;

endmodule
